// File: rtl/stereo_frame_capture.sv
// Captures one left/right stereo frame pair into two on-chip stores and serves
// zero-latency reads to the disparity engine until the pair is released.
//
// state   | meaning
// IDLE    | waiting for capture; stores hold the last pair
// ARM     | each side waits for a beat carrying sof
// CAPTURE | at least one side started; sides fill independently
// READY   | both frames stored and frozen; engine may read
module stereo_frame_capture #(
   parameter int IMG_W = 20,
   parameter int IMG_H = 7,
   parameter int PIX_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             capture,
   input  logic             frame_release,
   input  logic             l_valid,
   input  logic             l_sof,
   input  logic [PIX_W-1:0] l_data,
   input  logic             r_valid,
   input  logic             r_sof,
   input  logic [PIX_W-1:0] r_data,
   input  logic [9:0]       rd_href,
   input  logic [9:0]       rd_vref,
   input  logic             rd_sel,
   output logic [PIX_W-1:0] image_data,
   output logic             buffer_ready,
   output logic             busy,
   output logic             sync_err,
   output logic [1:0]       state
);

   localparam int DEPTH = IMG_W * IMG_H;
   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = $clog2(IMG_W);
   localparam int RW    = $clog2(IMG_H);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      CAPTURE = 2'd2,
      READY   = 2'd3
   } state_t;

   state_t cur, nxt;

   logic [1:0]         valid, sof, done, strt, rstrt, last;
   logic [2*PIX_W-1:0] rd_words;
   logic [AW-1:0]      rd_addr;
   logic               rd_ok, clr, writing;

   assign valid   = {r_valid, l_valid};
   assign sof     = {r_sof, l_sof};
   assign clr     = (cur == IDLE) && capture;
   assign writing = (cur == ARM) || (cur == CAPTURE);

   for (genvar s = 0; s < 2; s++) begin : g_side
      logic [CW-1:0]    col;
      logic [RW-1:0]    row;
      logic             started, done_r, we, at_end, st, rs;
      logic [AW-1:0]    wa;
      logic [PIX_W-1:0] wd;
      logic [PIX_W-1:0] mem [DEPTH];

      assign wd     = (s == 0) ? l_data : r_data;
      assign at_end = (col == CW'(IMG_W - 1)) && (row == RW'(IMG_H - 1));

      // sof before the side starts opens the frame; sof after that restarts it
      always_comb begin
         we = 1'b0;
         st = 1'b0;
         rs = 1'b0;
         wa = AW'(row) * AW'(IMG_W) + AW'(col);
         if (writing && valid[s]) begin
            if (!started) begin
               if (sof[s]) begin
                  we = 1'b1;
                  st = 1'b1;
                  wa = '0;
               end
            end else if (!done_r) begin
               we = 1'b1;
               if (sof[s]) begin
                  rs = 1'b1;
                  wa = '0;
               end
            end
         end
      end

      assign strt[s]  = st;
      assign rstrt[s] = rs;
      assign last[s]  = we && !st && !rs && at_end;
      assign done[s]  = done_r;

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            col     <= '0;
            row     <= '0;
            started <= 1'b0;
            done_r  <= 1'b0;
         end else if (clr) begin
            col     <= '0;
            row     <= '0;
            started <= 1'b0;
            done_r  <= 1'b0;
         end else if (we) begin
            if (st || rs) begin
               col <= CW'(1);
               row <= '0;
            end else if (at_end) begin
               done_r <= 1'b1;
            end else if (col == CW'(IMG_W - 1)) begin
               col <= '0;
               row <= row + RW'(1);
            end else begin
               col <= col + CW'(1);
            end
            if (st) started <= 1'b1;
         end
      end

      always_ff @(posedge clk) begin
         if (we) mem[wa] <= wd;
      end

      assign rd_words[s*PIX_W +: PIX_W] = mem[rd_addr];
   end

   assign rd_ok      = (rd_href < 10'(IMG_W)) && (rd_vref < 10'(IMG_H));
   assign rd_addr    = AW'(rd_vref) * AW'(IMG_W) + AW'(rd_href);
   assign image_data = rd_ok ? rd_words[rd_sel*PIX_W +: PIX_W] : '0;

   always_comb begin
      nxt = cur;
      case (cur)
         IDLE:    if (capture) nxt = ARM;
         ARM:     if (|strt) nxt = CAPTURE;
         CAPTURE: if ((done[0] || last[0]) && (done[1] || last[1])) nxt = READY;
         READY:   if (frame_release) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cur          <= IDLE;
         buffer_ready <= 1'b0;
         sync_err     <= 1'b0;
      end else begin
         cur          <= nxt;
         buffer_ready <= (nxt == READY);
         if (clr)
            sync_err <= 1'b0;
         else if (|rstrt)
            sync_err <= 1'b1;
      end
   end

   assign busy  = (cur == ARM) || (cur == CAPTURE);
   assign state = cur;

endmodule

// File: tb/tb_stereo_frame_capture.sv
// Directed bench for stereo_frame_capture: sequencing, sync errors, read path.
module tb_stereo_frame_capture;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       capture = 1'b0;
   logic       frame_release = 1'b0;
   logic       l_valid = 1'b0, l_sof = 1'b0, r_valid = 1'b0, r_sof = 1'b0;
   logic [7:0] l_data = '0, r_data = '0;
   logic [9:0] rd_href = '0, rd_vref = '0;
   logic       rd_sel = 1'b0;
   logic [7:0] image_data;
   logic       buffer_ready, busy, sync_err;
   logic [1:0] state;

   int n_chk = 0;
   int n_err = 0;

   stereo_frame_capture dut (
      .clk(clk), .reset(reset), .capture(capture), .frame_release(frame_release),
      .l_valid(l_valid), .l_sof(l_sof), .l_data(l_data),
      .r_valid(r_valid), .r_sof(r_sof), .r_data(r_data),
      .rd_href(rd_href), .rd_vref(rd_vref), .rd_sel(rd_sel),
      .image_data(image_data), .buffer_ready(buffer_ready), .busy(busy),
      .sync_err(sync_err), .state(state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input bit lv, input bit ls, input logic [7:0] ld,
                       input bit rv, input bit rs, input logic [7:0] rdd);
      l_valid = lv; l_sof = ls; l_data = ld;
      r_valid = rv; r_sof = rs; r_data = rdd;
      tick();
      l_valid = 1'b0; l_sof = 1'b0; r_valid = 1'b0; r_sof = 1'b0;
   endtask

   task automatic pulse_cap;
      capture = 1'b1;
      tick();
      capture = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input int h, input int v, input bit sel,
                         input logic [7:0] exp);
      rd_href = 10'(h);
      rd_vref = 10'(v);
      rd_sel  = sel;
      #1;
      chk(tag, 32'(image_data), 32'(exp));
   endtask

   initial begin
      int li, ri, bad;
      bit lv, rv;

      #12;
      chk("reset_outputs", {28'd0, state, buffer_ready, busy}, 32'd0);
      chk("reset_sync_err", 32'(sync_err), 32'd0);
      reset = 1'b1;
      tick();

      // valid beats without sof are ignored while armed
      pulse_cap();
      chk("arm_state", 32'(state), 32'd1);
      repeat (5) beat(1, 0, 8'h11, 1, 0, 8'h22);
      chk("arm_no_sof", {30'd0, state}, 32'd1);
      chk("arm_busy", 32'(busy), 32'd1);

      // reset in the middle of a capture
      beat(1, 1, 8'h10, 1, 1, 8'h80);
      chk("start_capture", 32'(state), 32'd2);
      repeat (9) beat(1, 0, 8'h00, 1, 0, 8'h00);
      #2 reset = 1'b0;
      #1;
      chk("midcap_reset", {28'd0, state, buffer_ready, busy}, 32'd0);
      tick();
      reset = 1'b1;
      tick();
      pulse_cap();
      chk("rearm", 32'(state), 32'd1);

      // aligned full frames
      for (int i = 0; i < 140; i++) begin
         beat(1, i == 0, 8'(8'h10 + i), 1, i == 0, 8'(8'h80 + i));
         if (i == 138) chk("br_before_last", 32'(buffer_ready), 32'd0);
      end
      chk("br_after_last", 32'(buffer_ready), 32'd1);
      chk("ready_state", {30'd0, state}, 32'd3);
      chk("ready_not_busy", 32'(busy), 32'd0);
      rd_chk("rd_l_5_2", 5, 2, 0, 8'h3D);
      rd_chk("rd_r_5_2", 5, 2, 1, 8'hAD);
      rd_chk("rd_r_corner", 19, 6, 1, 8'h0B);
      rd_chk("rd_l_origin", 0, 0, 0, 8'h10);

      // READY freezes stores and ignores capture
      pulse_cap();
      chk("cap_in_ready", 32'(state), 32'd3);
      repeat (20) beat(1, 1, 8'hEE, 1, 1, 8'hEE);
      chk("ready_hold", 32'(state), 32'd3);
      rd_chk("frozen_l", 5, 2, 0, 8'h3D);
      rd_chk("frozen_r", 0, 0, 1, 8'h80);
      rd_chk("href_oob", 20, 0, 0, 8'h00);
      rd_chk("vref_oob", 0, 7, 1, 8'h00);
      frame_release = 1'b1;
      tick();
      frame_release = 1'b0;
      chk("release_idle", {29'd0, state, buffer_ready}, 32'd0);

      // skewed streams, left gapped 1-of-3, right delayed by 37 cycles
      pulse_cap();
      li = 0; ri = 0; bad = 0;
      for (int t = 0; t < 600 && !(li == 140 && ri == 140); t++) begin
         lv = (t % 3 == 0) && (li < 140);
         rv = (t >= 37) && (ri < 140);
         beat(lv, lv && li == 0, 8'(8'h10 + li), rv, rv && ri == 0, 8'(8'h80 + ri));
         if (lv) li++;
         if (rv) ri++;
         if (buffer_ready !== (li == 140 && ri == 140)) bad++;
      end
      chk("skew_ready_timing", 32'(bad), 32'd0);
      chk("skew_ready", 32'(buffer_ready), 32'd1);
      chk("skew_sync_ok", 32'(sync_err), 32'd0);
      rd_chk("skew_l", 5, 2, 0, 8'h3D);
      rd_chk("skew_r", 5, 2, 1, 8'hAD);

      // release wins over a simultaneous capture
      capture = 1'b1;
      frame_release = 1'b1;
      tick();
      capture = 1'b0;
      frame_release = 1'b0;
      chk("cap_rel_idle", 32'(state), 32'd0);
      tick();
      chk("cap_rel_no_arm", 32'(state), 32'd0);

      // left restarts mid-frame; right finishes first then sends ignored sof
      pulse_cap();
      for (int i = 0; i < 50; i++) beat(1, i == 0, 8'h55, 1, i == 0, 8'(8'h80 + i));
      chk("no_sync_err_yet", 32'(sync_err), 32'd0);
      for (int j = 0; j < 140; j++) begin
         if (50 + j < 140) beat(1, j == 0, 8'(8'h10 + j), 1, 0, 8'(8'h80 + 50 + j));
         else beat(1, j == 0, 8'(8'h10 + j), 1, 1, 8'hEE);
         if (j == 0) chk("sync_err_set", 32'(sync_err), 32'd1);
         if (j == 100) chk("wait_both_done", 32'(state), 32'd2);
      end
      chk("resync_ready", 32'(buffer_ready), 32'd1);
      chk("sync_err_sticky", 32'(sync_err), 32'd1);
      rd_chk("resync_l", 5, 2, 0, 8'h3D);
      rd_chk("resync_l_origin", 0, 0, 0, 8'h10);
      rd_chk("done_r_intact", 5, 2, 1, 8'hAD);
      frame_release = 1'b1;
      tick();
      frame_release = 1'b0;
      chk("sync_err_idle", 32'(sync_err), 32'd1);
      pulse_cap();
      chk("sync_err_cleared", 32'(sync_err), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
